candle_sequencer: RTL
=====================

// Module: candle_sequencer
// PURPOSE
//  Upstream command stage for candle_controller: accepts host commands over a valid/ready handshake
//  and emits timed single-cycle set/clear pulses (pos_to_set/set_enable, pos_to_clear/clear_enable).
//  Multi-candle commands are spread out with a programmable gap for a visible lighting effect.
//  Keeps a shadow copy of candle_state so it can skip lit/unlit candles and report status.
// PARAMETERS
//  NUM_CANDLES  8           number of candles; fixed at 8 in this revision
//  POS_W        3           candle index width, $clog2(NUM_CANDLES)
//  STEP_CYCLES  25_000_000  idle cycles inserted after each pulse of a multi-candle sequence; must be >= 1
// PORTS
//  sys_clk       in   1      clock
//  clr_async     in   1      reset, asynchronous, active-high
//  cmd_valid     in   1      command present
//  cmd_ready     out  1      sequencer can accept a command (high only in IDLE)
//  cmd_op        in   2      00 LIGHT_UPTO, 01 EXTINGUISH_ALL, 10 SET_ONE, 11 CLEAR_ONE
//  cmd_arg       in   POS_W  candle index: LIGHT_UPTO upper bound, SET_ONE/CLEAR_ONE target; ignored for EXTINGUISH_ALL
//  abort         in   1      terminate the running sequence
//  pos_to_set    out  POS_W  index for set pulse
//  set_enable    out  1      one-cycle set pulse
//  pos_to_clear  out  POS_W  index for clear pulse
//  clear_enable  out  1      one-cycle clear pulse
//  shadow_state  out  8      mirror of downstream candle_state
//  busy          out  1      ~cmd_ready
//  done          out  1      one-cycle pulse when a command completes
// BEHAVIOUR
//  Reset (async): state=IDLE; cmd_ready=1; busy=0; enables=0; positions=0; shadow_state=0; done=0.
//  Accept: cmd_valid & cmd_ready at edge t0. Command fields are latched at that edge.
//   - cmd_valid while busy is ignored. The host holds the command until it is accepted.
//  FSM states: IDLE, SCAN, WAIT.
//   - SCAN processes one index per cycle.
//   - WAIT counts STEP_CYCLES cycles, then returns to SCAN at the next index.
//  SET_ONE/CLEAR_ONE:
//   - Pulse asserted in cycle t0+1 at index cmd_arg, always issued even if already in that state.
//   - done is asserted in the same cycle; cmd_ready rises in t0+2.
//  LIGHT_UPTO N: scan index 0 up to N.
//   - Lit index: skip, 1 cycle, no pulse, no wait.
//   - Unlit index: set pulse; then WAIT unless index==N.
//  EXTINGUISH_ALL: scan index 7 down to 0.
//   - Unlit index: skip, 1 cycle, no pulse, no wait.
//   - Lit index: clear pulse; then WAIT unless index==0.
//  Pulse spacing: two consecutive pulses with no skips between them are STEP_CYCLES+1 cycles apart.
//  done:
//   - Asserted in the cycle the final index is processed, whether it pulses or skips.
//   - FSM is IDLE with cmd_ready=1 in the next cycle.
//  shadow_state: bit updated at the clock edge that ends the pulse cycle, the same edge as candle_controller.
//  set_enable and clear_enable are never high in the same cycle. Positions hold their last value when enables are low.
//  abort (sampled in SCAN/WAIT):
//   - Returns to IDLE at the next edge.
//   - A pulse in the current cycle still completes. No further pulses. done is NOT asserted.
//   - abort in IDLE has no effect.
//  clr_async mid-sequence: immediate return to reset values. The sequence is lost and not resumed.
//  Width rules: index counter is POS_W bits, no wrap. Termination is by compare (==N or ==0), never by overflow.
//   - WAIT counter is $clog2(STEP_CYCLES+1) bits.
// STRUCTURE
//  candle_pkg (shared): NUM_CANDLES, POS_W, typedef enum logic[1:0] cmd_op_e {LIGHT_UPTO, EXTINGUISH_ALL, SET_ONE, CLEAR_ONE}.
//  FSM state enum is local to this module.
//  Sub-module step_timer: loadable down-counter, inputs load/clr_async, output expire.
//   - Instantiated once with STEP_CYCLES.
// TESTING (bench uses STEP_CYCLES=4, candle_controller instantiated downstream, its state compared to shadow_state)
//  1 Reset pulse -> cmd_ready=1, busy=0, set/clear_enable=0, shadow_state=8'h00.
//  2 SET_ONE arg=5 accepted at t0:
//    - set_enable=1, pos_to_set=5 in t0+1, with done=1.
//    - t0+2: shadow=8'h20, cmd_ready=1.
//  3 shadow=8'h04, LIGHT_UPTO arg=3 at t0:
//    - Set pulses idx0 @t0+1 and idx1 @t0+6; idx2 skipped @t0+11.
//    - idx3 pulse with done @t0+12; shadow=8'h0F.
//  4 shadow=8'h81, EXTINGUISH_ALL at t0:
//    - clear idx7 @t0+1; idx6..1 skipped over t0+6..t0+11.
//    - clear idx0 with done @t0+12; shadow=8'h00.
//  5 abort during the first WAIT of test 3 -> IDLE next cycle, no further pulses, done never high, shadow=8'h05.
//  6 clr_async mid-WAIT -> all outputs reset immediately; a command held on cmd_valid during busy is accepted on the first cycle after reset release.

Source files
------------

// File: rtl/candle_pkg.sv
// Shared definitions for the candle command path: sizing, command opcodes and
// the index-walking helpers used by the sequencer.
package candle_pkg;

  localparam int NUM_CANDLES = 8;
  localparam int POS_W       = $clog2(NUM_CANDLES);

  typedef enum logic [1:0] {
    LIGHT_UPTO     = 2'b00,
    EXTINGUISH_ALL = 2'b01,
    SET_ONE        = 2'b10,
    CLEAR_ONE      = 2'b11
  } cmd_op_e;

  function automatic logic [POS_W-1:0] start_idx(cmd_op_e op, logic [POS_W-1:0] arg);
    unique case (op)
      LIGHT_UPTO:     start_idx = '0;
      EXTINGUISH_ALL: start_idx = POS_W'(NUM_CANDLES - 1);
      default:        start_idx = arg;
    endcase
  endfunction

  // Callers only step when the current index is not final, so neither direction wraps.
  function automatic logic [POS_W-1:0] next_idx(cmd_op_e op, logic [POS_W-1:0] idx);
    if (op == EXTINGUISH_ALL) next_idx = idx - 1'b1;
    else                      next_idx = idx + 1'b1;
  endfunction

  function automatic logic is_final(cmd_op_e op, logic [POS_W-1:0] idx, logic [POS_W-1:0] arg);
    unique case (op)
      LIGHT_UPTO:     is_final = (idx == arg);
      EXTINGUISH_ALL: is_final = (idx == '0);
      default:        is_final = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/candle_sequencer_step_timer.sv
// Loadable down-counter that times the idle gap between lighting-effect pulses.
// expire is high during the last of STEP_CYCLES counted cycles after a load.
module step_timer #(
  parameter int STEP_CYCLES = 25_000_000
) (
  input  logic sys_clk,
  input  logic clr_async,
  input  logic load,
  output logic expire
);

  localparam int              CNT_W    = $clog2(STEP_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(STEP_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge sys_clk or posedge clr_async) begin
    if (clr_async)           cnt_q <= '0;
    else if (load)           cnt_q <= LOAD_VAL;
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/candle_sequencer.sv
// Host command front end for candle_controller: turns accepted commands into
// spaced single-cycle set/clear pulses while tracking a shadow of candle_state.
module candle_sequencer
  import candle_pkg::*;
#(
  parameter int STEP_CYCLES = 25_000_000
) (
  input  logic                   sys_clk,
  input  logic                   clr_async,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [POS_W-1:0]       cmd_arg,
  input  logic                   abort,
  output logic [POS_W-1:0]       pos_to_set,
  output logic                   set_enable,
  output logic [POS_W-1:0]       pos_to_clear,
  output logic                   clear_enable,
  output logic [NUM_CANDLES-1:0] shadow_state,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT} state_e;

  state_e                 state_q, state_d;
  cmd_op_e                op_q, op_d;
  logic [POS_W-1:0]       arg_q, arg_d;
  logic [POS_W-1:0]       idx_q, idx_d;
  logic                   set_en_q, set_en_d;
  logic                   clr_en_q, clr_en_d;
  logic [POS_W-1:0]       pos_set_q, pos_set_d;
  logic [POS_W-1:0]       pos_clr_q, pos_clr_d;
  logic [NUM_CANDLES-1:0] shadow_q, shadow_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;
  logic                   enter_scan;
  logic                   timer_load;
  logic                   timer_expire;

  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
    .sys_clk   (sys_clk),
    .clr_async (clr_async),
    .load      (timer_load),
    .expire    (timer_expire)
  );

  // Outputs are registered, so the pulse for an index is decided on the edge
  // that enters its SCAN cycle, using the shadow as it will be after that edge.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    arg_d      = arg_q;
    idx_d      = idx_q;
    enter_scan = 1'b0;
    timer_load = 1'b0;

    shadow_d = shadow_q;
    if (set_en_q) shadow_d[pos_set_q] = 1'b1;
    if (clr_en_q) shadow_d[pos_clr_q] = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op_e'(cmd_op);
          arg_d      = cmd_arg;
          idx_d      = start_idx(cmd_op_e'(cmd_op), cmd_arg);
          state_d    = S_SCAN;
          enter_scan = 1'b1;
        end
      end
      S_SCAN: begin
        if (abort || done_q) begin
          state_d = S_IDLE;
        end else if (set_en_q || clr_en_q) begin
          state_d    = S_WAIT;
          timer_load = 1'b1;
        end else begin
          idx_d      = next_idx(op_q, idx_q);
          enter_scan = 1'b1;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (timer_expire) begin
          idx_d      = next_idx(op_q, idx_q);
          state_d    = S_SCAN;
          enter_scan = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    set_en_d  = 1'b0;
    clr_en_d  = 1'b0;
    done_d    = 1'b0;
    pos_set_d = pos_set_q;
    pos_clr_d = pos_clr_q;
    if (enter_scan) begin
      unique case (op_d)
        LIGHT_UPTO:     set_en_d = ~shadow_d[idx_d];
        EXTINGUISH_ALL: clr_en_d = shadow_d[idx_d];
        SET_ONE:        set_en_d = 1'b1;
        default:        clr_en_d = 1'b1;
      endcase
      if (set_en_d) pos_set_d = idx_d;
      if (clr_en_d) pos_clr_d = idx_d;
      done_d = is_final(op_d, idx_d, arg_d);
    end

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge sys_clk or posedge clr_async) begin
    if (clr_async) begin
      state_q   <= S_IDLE;
      set_en_q  <= 1'b0;
      clr_en_q  <= 1'b0;
      pos_set_q <= '0;
      pos_clr_q <= '0;
      shadow_q  <= '0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      set_en_q  <= set_en_d;
      clr_en_q  <= clr_en_d;
      pos_set_q <= pos_set_d;
      pos_clr_q <= pos_clr_d;
      shadow_q  <= shadow_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  // Latched command and scan position only matter outside IDLE.
  always_ff @(posedge sys_clk) begin
    op_q  <= op_d;
    arg_q <= arg_d;
    idx_q <= idx_d;
  end

  assign cmd_ready    = ready_q;
  assign busy         = ~ready_q;
  assign set_enable   = set_en_q;
  assign clear_enable = clr_en_q;
  assign pos_to_set   = pos_set_q;
  assign pos_to_clear = pos_clr_q;
  assign shadow_state = shadow_q;
  assign done         = done_q;

endmodule
